// File: rtl/turn_sequencer.sv
// -----------------------------------------------------------------------------
// turn_sequencer
//
// Game-flow controller for the 16x16 five-in-a-row board. It turns the raw,
// bouncy "put" push-button into exactly one validated board write per press.
// After each write it waits for the win checker to settle and samples its
// verdict. It then alternates turns or ends the game on a win or a draw.
// All board updates happen on the system clock.
//
// Ports
//   clock       in   1  system clock, rising edge
//   resetn      in   1  asynchronous active-low reset
//   put         in   1  raw asynchronous put button (1 = pressed)
//   coordi      in   8  cursor position, [7:4] row, [3:0] column
//   cell_state  in   2  contents of cell at cell_addr: 00 empty, 01 p0, 10 p1
//   check_ans   in   2  win checker: 00 none, 01 p0 wins, 10 p1 wins,
//                       11 the player who just moved wins
//   cell_addr   out  8  latched move coordinate (read mux and write address)
//   wr_en       out  1  one-cycle board write strobe
//   wr_color    out  2  colour to write, equals turn while wr_en is high
//   turn        out  2  player to move: 01 p0, 10 p1
//   illegal     out  1  one-cycle pulse when a move targets an occupied cell
//   winner      out  2  winning player, sticky until reset
//   draw        out  1  board full with no winner, sticky until reset
//   game_over   out  1  winner != 00 or draw
//   move_count  out  9  accepted moves, 0..BOARD_CELLS
// -----------------------------------------------------------------------------
module turn_sequencer #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CHECK_WAIT      = 2,
   parameter int BOARD_CELLS     = 256
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       put,
   input  logic [7:0] coordi,
   input  logic [1:0] cell_state,
   input  logic [1:0] check_ans,
   output logic [7:0] cell_addr,
   output logic       wr_en,
   output logic [1:0] wr_color,
   output logic [1:0] turn,
   output logic       illegal,
   output logic [1:0] winner,
   output logic       draw,
   output logic       game_over,
   output logic [8:0] move_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW_W = $clog2(CHECK_WAIT + 1);
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW_W-1:0] CW_LAST    = CW_W'(CHECK_WAIT - 1);
   localparam logic [8:0]      LAST_MOVE  = 9'(BOARD_CELLS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_READ,
      S_WRITE,
      S_CHECK,
      S_TURN,
      S_OVER
   } state_t;

   state_t            state;
   logic              put_meta;
   logic              put_sync;
   logic              put_filt;
   logic              put_filt_q;
   logic [DB_W-1:0]   db_cnt;
   logic [CW_W-1:0]   check_cnt;
   logic              put_evt;

   // ---------------------------------------------------------------------------
   // Input conditioning: 2-FF synchroniser, then a filter that only follows the
   // synchronised level once it has disagreed for DEBOUNCE_CYCLES cycles in a row.
   // Any agreeing sample restarts the count, so short glitches never get through.
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would collapse the synchroniser chain.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         put_meta   <= 1'b0;
         put_sync   <= 1'b0;
         put_filt   <= 1'b0;
         put_filt_q <= 1'b0;
         db_cnt     <= '0;
      end else begin
         put_meta   <= put;
         put_sync   <= put_meta;
         put_filt_q <= put_filt;
         if (put_sync == put_filt) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            put_filt <= put_sync;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // One-cycle pulse on each filtered press; holding the button gives one event.
   assign put_evt = put_filt & ~put_filt_q;

   // ---------------------------------------------------------------------------
   // Move sequencer. Events arriving outside S_IDLE are simply not looked at,
   // which drops them rather than queueing them.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         turn       <= 2'b01;
         cell_addr  <= 8'h00;
         wr_en      <= 1'b0;
         wr_color   <= 2'b00;
         illegal    <= 1'b0;
         winner     <= 2'b00;
         draw       <= 1'b0;
         game_over  <= 1'b0;
         move_count <= 9'd0;
         check_cnt  <= '0;
      end else begin
         // NOTE: strobes default low every cycle and are raised only by the
         // state that owns them, so each is exactly one cycle wide.
         wr_en   <= 1'b0;
         illegal <= 1'b0;

         case (state)
            S_IDLE: begin
               if (put_evt) state <= S_LATCH;
            end

            S_LATCH: begin
               cell_addr <= coordi;
               state     <= S_READ;
            end

            // cell_state has had one full cycle to follow the new cell_addr.
            S_READ: begin
               if (cell_state != 2'b00) begin
                  illegal <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  wr_en    <= 1'b1;
                  wr_color <= turn;
                  state    <= S_WRITE;
               end
            end

            S_WRITE: begin
               wr_color  <= 2'b00;
               check_cnt <= '0;
               state     <= S_CHECK;
            end

            // Give the win checker CHECK_WAIT cycles to see the new stone.
            S_CHECK: begin
               if (check_cnt == CW_LAST) begin
                  move_count <= move_count + 9'd1;
                  if (check_ans == 2'b11) begin
                     winner    <= turn;
                     game_over <= 1'b1;
                     state     <= S_OVER;
                  end else if (check_ans != 2'b00) begin
                     winner    <= check_ans;
                     game_over <= 1'b1;
                     state     <= S_OVER;
                  end else if (move_count == LAST_MOVE) begin
                     draw      <= 1'b1;
                     game_over <= 1'b1;
                     state     <= S_OVER;
                  end else begin
                     state <= S_TURN;
                  end
               end else begin
                  check_cnt <= check_cnt + 1'b1;
               end
            end

            S_TURN: begin
               turn  <= ~turn;
               state <= S_IDLE;
            end

            // Absorbing: turn keeps the last mover's colour until reset.
            S_OVER: begin
               state <= S_OVER;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_turn_sequencer
//
// Self-checking bench for turn_sequencer with DEBOUNCE_CYCLES=4, CHECK_WAIT=2.
// A game-level reference model (board array, player to move, move tally,
// winner/draw flags) predicts the outcome of each button press. The board
// array also plays the role of the board memory feeding cell_state.
// -----------------------------------------------------------------------------
module tb_turn_sequencer;

   localparam int DB     = 4;
   localparam int CW     = 2;
   localparam int CELLS  = 256;
   localparam int SETTLE = 12;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       put = 1'b0;
   logic [7:0] coordi = 8'h00;
   logic [1:0] cell_state;
   logic [1:0] check_ans = 2'b00;
   logic [7:0] cell_addr;
   logic       wr_en;
   logic [1:0] wr_color;
   logic [1:0] turn;
   logic       illegal;
   logic [1:0] winner;
   logic       draw;
   logic       game_over;
   logic [8:0] move_count;

   turn_sequencer #(
      .DEBOUNCE_CYCLES (DB),
      .CHECK_WAIT      (CW),
      .BOARD_CELLS     (CELLS)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .put        (put),
      .coordi     (coordi),
      .cell_state (cell_state),
      .check_ans  (check_ans),
      .cell_addr  (cell_addr),
      .wr_en      (wr_en),
      .wr_color   (wr_color),
      .turn       (turn),
      .illegal    (illegal),
      .winner     (winner),
      .draw       (draw),
      .game_over  (game_over),
      .move_count (move_count)
   );

   always #5 clock = ~clock;

   // Reference model state
   logic [1:0] board [CELLS];
   int         ref_turn;
   int         ref_count;
   int         ref_winner;
   bit         ref_draw;

   assign cell_state = board[cell_addr];

   int checks = 0;
   int errors = 0;

   // Cycle counter and output monitor (sampled on the falling edge)
   int         cyc = 0;
   int         wr_cnt = 0;
   int         ill_cnt = 0;
   int         wr_cyc = 0;
   int         turn_cyc = 0;
   logic [7:0] wr_addr = 8'h00;
   logic [1:0] wr_col = 2'b00;
   logic [1:0] turn_prev = 2'b01;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= cell_addr;
         wr_col  <= wr_color;
         wr_cyc  <= cyc;
      end
      if (illegal === 1'b1) ill_cnt <= ill_cnt + 1;
      turn_prev <= turn;
      if (turn !== turn_prev) turn_cyc <= cyc;
   end

   localparam logic [26:0] RESET_VEC = {8'h00, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 9'd0};

   task automatic model_clear();
      ref_turn   = 1;
      ref_count  = 0;
      ref_winner = 0;
      ref_draw   = 1'b0;
      for (int i = 0; i < CELLS; i++) board[i] = 2'b00;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      resetn    = 1'b0;
      put       = 1'b0;
      check_ans = 2'b00;
      model_clear();
      repeat (3) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   // One complete button press; the model decides what the DUT must do.
   task automatic play_move(input string tag, input logic [7:0] coord, input logic [1:0] ans,
                            input int hold, input bit force_drop);
      int w0, i0, start, mover, exp_wr, exp_ill;
      bit over;
      over    = (ref_winner != 0) || ref_draw;
      exp_wr  = (!over && board[coord] == 2'b00) ? 1 : 0;
      exp_ill = (!over && board[coord] != 2'b00) ? 1 : 0;
      mover   = ref_turn;
      w0      = wr_cnt;
      i0      = ill_cnt;
      check_ans = ans;
      @(posedge clock); #1;
      coordi = coord;
      put    = 1'b1;
      start  = cyc;
      for (int k = 1; k <= hold; k++) begin
         @(posedge clock); #1;
         if (force_drop && k == 10) force dut.put_evt = 1'b1;
         if (force_drop && k == 11) release dut.put_evt;
      end
      coordi = 8'($urandom);
      put    = 1'b0;
      repeat (SETTLE) @(posedge clock);
      @(negedge clock); #1;

      checks++;
      if (wr_cnt - w0 !== exp_wr) begin
         errors++;
         $display("FAIL %s wr_en_pulses got %0d exp %0d", tag, wr_cnt - w0, exp_wr);
      end
      checks++;
      if (ill_cnt - i0 !== exp_ill) begin
         errors++;
         $display("FAIL %s illegal_cycles got %0d exp %0d", tag, ill_cnt - i0, exp_ill);
      end

      if (exp_wr == 1) begin
         board[coord] = 2'(mover);
         ref_count++;
         checks++;
         if (wr_addr !== coord || wr_col !== 2'(mover)) begin
            errors++;
            $display("FAIL %s write got addr %h col %b exp addr %h col %b",
                     tag, wr_addr, wr_col, coord, 2'(mover));
         end
         checks++;
         if (wr_cyc - start !== DB + 5) begin
            errors++;
            $display("FAIL %s put_to_wr_latency got %0d exp %0d", tag, wr_cyc - start, DB + 5);
         end
         if (ans != 2'b00) begin
            ref_winner = (ans == 2'b11) ? mover : int'(ans);
         end else if (ref_count == CELLS) begin
            ref_draw = 1'b1;
         end else begin
            ref_turn = 3 - mover;
            checks++;
            if (turn_cyc - wr_cyc !== CW + 2) begin
               errors++;
               $display("FAIL %s wr_to_turn_latency got %0d exp %0d", tag, turn_cyc - wr_cyc, CW + 2);
            end
         end
      end

      checks++;
      if (turn !== 2'(ref_turn) || move_count !== 9'(ref_count)) begin
         errors++;
         $display("FAIL %s turn/move_count got %b/%0d exp %b/%0d",
                  tag, turn, move_count, 2'(ref_turn), ref_count);
      end
      checks++;
      if (winner !== 2'(ref_winner) || draw !== ref_draw ||
          game_over !== (ref_winner != 0 || ref_draw)) begin
         errors++;
         $display("FAIL %s winner/draw/game_over got %b/%b/%b exp %b/%b/%b", tag, winner, draw,
                  game_over, 2'(ref_winner), ref_draw, (ref_winner != 0 || ref_draw));
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      model_clear();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({cell_addr, wr_en, wr_color, turn, illegal, winner, draw, game_over, move_count} !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_values got %h exp %h",
                  {cell_addr, wr_en, wr_color, turn, illegal, winner, draw, game_over, move_count}, RESET_VEC);
      end
      @(posedge clock); #1 resetn = 1'b1;
   endtask

   task automatic test_legal_move();
      play_move("legal_0x34", 8'h34, 2'b00, 20, 1'b0);
   endtask

   task automatic test_occupied();
      play_move("occupied_0x34", 8'h34, 2'b00, 10, 1'b0);
   endtask

   task automatic test_bounce();
      int w0, i0, mc0;
      logic [1:0] t0;
      w0 = wr_cnt; i0 = ill_cnt; mc0 = ref_count; t0 = turn;
      @(posedge clock); #1;
      coordi = 8'h56;
      for (int p = 0; p < 12; p++) begin
         put = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clock);
         #1 put = 1'b0;
         @(posedge clock); #1;
      end
      repeat (SETTLE) @(posedge clock);
      @(negedge clock); #1;
      checks++;
      if (wr_cnt != w0 || ill_cnt != i0) begin
         errors++;
         $display("FAIL bounce pulses got wr %0d ill %0d exp 0 0", wr_cnt - w0, ill_cnt - i0);
      end
      checks++;
      if (move_count !== 9'(mc0) || turn !== t0) begin
         errors++;
         $display("FAIL bounce state got mc %0d turn %b exp %0d %b", move_count, turn, mc0, t0);
      end
   endtask

   // A put event injected while the move is in S_CHECK must be ignored.
   task automatic test_drop_in_check();
      play_move("drop_in_check", 8'hA7, 2'b00, 14, 1'b1);
   endtask

   task automatic test_win();
      play_move("win_p0_move", 8'h10, 2'b00, 9, 1'b0);
      play_move("win_p1_wins", 8'h11, 2'b10, 9, 1'b0);
      play_move("win_ignored_empty", 8'h22, 2'b00, 9, 1'b0);
      play_move("win_ignored_occupied", 8'h34, 2'b00, 9, 1'b0);
   endtask

   task automatic test_async_reset();
      logic [26:0] got;
      @(negedge clock); #1;
      resetn = 1'b0;
      #1;
      got = {cell_addr, wr_en, wr_color, turn, illegal, winner, draw, game_over, move_count};
      checks++;
      if (got !== RESET_VEC) begin
         errors++;
         $display("FAIL async_reset got %h exp %h", got, RESET_VEC);
      end
      model_clear();
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   task automatic test_random_win();
      int n;
      logic [7:0] c;
      apply_reset();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
         c = 8'($urandom);
         for (int g = 0; g < 64 && board[c] != 2'b00; g++) c = 8'($urandom);
         play_move("rnd_move", c, 2'b00, $urandom_range(8, 12), 1'b0);
         if (i == 1) play_move("rnd_occupied", c, 2'b00, 8, 1'b0);
      end
      c = 8'($urandom);
      for (int g = 0; g < 64 && board[c] != 2'b00; g++) c = 8'($urandom);
      play_move("rnd_final", c, 2'($urandom_range(1, 3)), 9, 1'b0);
      play_move("rnd_after_over", 8'($urandom), 2'b00, 9, 1'b0);
   endtask

   task automatic test_draw();
      int order [CELLS];
      int j, tmp;
      apply_reset();
      for (int i = 0; i < CELLS; i++) order[i] = i;
      for (int i = CELLS - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < CELLS; i++) begin
         if (i > 0 && i % 32 == 7)
            play_move("draw_occupied", 8'(order[$urandom_range(0, i - 1)]), 2'b00, 8, 1'b0);
         play_move("draw_move", 8'(order[i]), 2'b00, $urandom_range(8, 12), 1'b0);
      end
      checks++;
      if (draw !== 1'b1 || game_over !== 1'b1 || move_count !== 9'd256 || winner !== 2'b00) begin
         errors++;
         $display("FAIL draw_final got draw %b over %b mc %0d win %b exp 1 1 256 00",
                  draw, game_over, move_count, winner);
      end
      play_move("draw_after_over", 8'($urandom), 2'b00, 9, 1'b0);
   endtask

   task automatic test_reset_in_check();
      int w0;
      logic [26:0] got;
      apply_reset();
      w0 = wr_cnt;
      @(posedge clock); #1;
      coordi = 8'h5A;
      put    = 1'b1;
      repeat (11) @(posedge clock);
      #1;
      checks++;
      if (wr_cnt - w0 !== 1) begin
         errors++;
         $display("FAIL rst_in_check write_before got %0d exp 1", wr_cnt - w0);
      end
      resetn = 1'b0;
      #1;
      got = {cell_addr, wr_en, wr_color, turn, illegal, winner, draw, game_over, move_count};
      checks++;
      if (got !== RESET_VEC) begin
         errors++;
         $display("FAIL rst_in_check values got %h exp %h", got, RESET_VEC);
      end
      put = 1'b0;
      repeat (3) @(posedge clock);
      #1 resetn = 1'b1;
      repeat (SETTLE) @(posedge clock);
      @(negedge clock); #1;
      checks++;
      if (turn !== 2'b01 || move_count !== 9'd0 || wr_cnt - w0 !== 1) begin
         errors++;
         $display("FAIL rst_in_check late_effects got turn %b mc %0d wr %0d exp 01 0 1",
                  turn, move_count, wr_cnt - w0);
      end
      play_move("after_rst_in_check", 8'h5A, 2'b00, 8, 1'b0);
   endtask

   initial begin
      test_reset();
      test_legal_move();
      test_occupied();
      test_bounce();
      test_drop_in_check();
      test_win();
      test_async_reset();
      test_random_win();
      test_draw();
      test_reset_in_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
